// File: rtl/lsu_mem_port_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_port_if
// Memory-side bus of the load/store unit.
//   master modport : LSU side (drives request, address, strobes, write data)
//   slave  modport : memory side (drives grant and read return)
// Signals:
//   mem_req    request, held until mem_gnt
//   mem_we     write enable
//   mem_addr   word-aligned byte address, bits [1:0] always 0
//   mem_wstrb  byte strobes
//   mem_wdata  lane-shifted write data
//   mem_gnt    request accepted when mem_req && mem_gnt
//   mem_rvalid read data valid, one or more cycles after the grant
//   mem_rdata  read data
// -----------------------------------------------------------------------------
interface lsu_mem_port_if #(
  parameter int ADDR_W = 17
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
// Load/store unit memory port. Accepts one byte/half/word access from the
// pipeline, drives it onto a word-wide memory bus with byte strobes, and
// returns a sign/zero-extended load result with a one-cycle resp_valid pulse.
//
// Build option: MISALIGN_SPLIT_EN
//   defined   : misaligned accesses are split into two word accesses
//               (second word wraps at the top of the address space);
//               misalign_err is tied to 0.
//   undefined : misaligned accesses complete immediately with misalign_err=1,
//               resp_data=0 and no memory request.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only when idle)
//   alucode                 access type (ALU_LB ... ALU_SW encodings below)
//   is_load / is_store      access direction, exactly one must be set
//   addr, wdata             byte address, right-aligned store data
//   resp_valid              one-cycle completion pulse
//   resp_data               extended load data, 0 for stores
//   misalign_err            qualifies resp_valid
//   mem                     memory bus (lsu_mem_port_if.master)
// -----------------------------------------------------------------------------
module lsu_mem_port #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        alucode,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              misalign_err,
  lsu_mem_port_if.master    mem
);

  // Access-type encodings shared with the core's decoder.
  localparam logic [5:0] ALU_LB  = 6'd11;
  localparam logic [5:0] ALU_LH  = 6'd12;
  localparam logic [5:0] ALU_LW  = 6'd13;
  localparam logic [5:0] ALU_LBU = 6'd14;
  localparam logic [5:0] ALU_LHU = 6'd15;
  localparam logic [5:0] ALU_SB  = 6'd16;
  localparam logic [5:0] ALU_SH  = 6'd17;
  localparam logic [5:0] ALU_SW  = 6'd18;

  typedef enum logic [2:0] {IDLE, REQ0, RD0, REQ1, RD1, DONE} state_t;

  // Access size: 0 byte, 1 half, 2 word.
  function automatic logic [1:0] size_of(input logic [5:0] code);
    logic [1:0] s;
    case (code)
      ALU_LB, ALU_LBU, ALU_SB: s = 2'd0;
      ALU_LH, ALU_LHU, ALU_SH: s = 2'd1;
      default:                 s = 2'd2;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'd1) && (off == 2'd3)) || ((size == 2'd2) && (off != 2'd0));
  endfunction

  // Exactly one direction bit set, and the alucode must belong to it.
  function automatic logic req_legal(input logic [5:0] code, input logic ld, input logic st);
    logic code_ld;
    logic code_st;
    code_ld = (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
              (code == ALU_LBU) || (code == ALU_LHU);
    code_st = (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    return (ld && !st && code_ld) || (st && !ld && code_st);
  endfunction

  state_t            state_reg, state_next;
  logic [5:0]        alu_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              load_reg;
  logic              err_reg;
  logic [31:0]       part0_reg;
  logic [31:0]       part1_reg;

  logic              accept;
  logic              skip_mem;
  logic              split;
  logic [1:0]        off;
  logic [1:0]        size;
  logic [3:0]        base_strb;
  logic [7:0]        strobe8;
  logic [63:0]       wdata64;
  logic [ADDR_W-3:0] word0, word1;
  logic [31:0]       rd_word;
  logic [31:0]       ld_ext;

  assign accept = req_valid && (state_reg == IDLE) && req_legal(alucode, is_load, is_store);

  // Datapath derived from the captured request.
  assign off  = addr_reg[1:0];
  assign size = size_of(alu_reg);

  always_comb begin
    base_strb = 4'b1111;
    case (size)
      2'd0:    base_strb = 4'b0001;
      2'd1:    base_strb = 4'b0011;
      default: base_strb = 4'b1111;
    endcase
  end

  assign strobe8 = {4'b0000, base_strb} << off;
  assign wdata64 = {32'h0, wdata_reg} << {off, 3'b000};
  assign word0   = addr_reg[ADDR_W-1:2];
  // Natural overflow of the word index gives the wrap to word 0.
  assign word1   = word0 + 1'b1;

`ifdef MISALIGN_SPLIT_EN
  // Any strobe spilling into the upper nibble means a second word is needed.
  assign split        = |strobe8[7:4];
  assign skip_mem     = 1'b0;
  assign misalign_err = 1'b0;
`else
  // Without splitting, only an aligned access ever reaches memory, so
  // REQ1/RD1 can never be entered.
  assign split        = 1'b0;
  assign skip_mem     = misaligned(size_of(alucode), addr[1:0]);
  assign misalign_err = (state_reg == DONE) && err_reg;
`endif

  // Realign the (possibly two-word) read data, then extend by access type.
  assign rd_word = 32'({part1_reg, part0_reg} >> {off, 3'b000});

  always_comb begin
    ld_ext = rd_word;
    case (alu_reg)
      ALU_LB:  ld_ext = {{24{rd_word[7]}}, rd_word[7:0]};
      ALU_LH:  ld_ext = {{16{rd_word[15]}}, rd_word[15:0]};
      ALU_LBU: ld_ext = {24'h0, rd_word[7:0]};
      ALU_LHU: ld_ext = {16'h0, rd_word[15:0]};
      default: ld_ext = rd_word;
    endcase
  end

  // State and captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      alu_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      load_reg  <= 1'b0;
      err_reg   <= 1'b0;
      part0_reg <= '0;
      part1_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_reg   <= alucode;
        addr_reg  <= addr;
        wdata_reg <= wdata;
        load_reg  <= is_load;
        err_reg   <= skip_mem;
        part0_reg <= '0;
        part1_reg <= '0;  // stays 0 for unsplit loads so the shift is clean
      end
      if ((state_reg == RD0) && mem.mem_rvalid) part0_reg <= mem.mem_rdata;
      if ((state_reg == RD1) && mem.mem_rvalid) part1_reg <= mem.mem_rdata;
    end
  end

  // Next state and outputs. Everything is decoded from state_reg, so reset
  // forces the idle output values without waiting for a clock.
  always_comb begin
    state_next     = state_reg;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = 32'h0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wstrb  = 4'b0000;
    mem.mem_wdata  = 32'h0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = skip_mem ? DONE : REQ0;
      end
      REQ0: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = !load_reg;
        mem.mem_addr  = {word0, 2'b00};
        mem.mem_wstrb = strobe8[3:0];
        mem.mem_wdata = load_reg ? 32'h0 : wdata64[31:0];
        if (mem.mem_gnt) state_next = load_reg ? RD0 : (split ? REQ1 : DONE);
      end
      RD0: begin
        if (mem.mem_rvalid) state_next = split ? REQ1 : DONE;
      end
      REQ1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = !load_reg;
        mem.mem_addr  = {word1, 2'b00};
        mem.mem_wstrb = strobe8[7:4];
        mem.mem_wdata = load_reg ? 32'h0 : wdata64[63:32];
        if (mem.mem_gnt) state_next = load_reg ? RD1 : DONE;
      end
      RD1: begin
        if (mem.mem_rvalid) state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_data  = (load_reg && !err_reg) ? ld_ext : 32'h0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_port
// Directed bench for lsu_mem_port: a word-addressed memory model with
// programmable grant and read-return delays, a response monitor, and
// hand-computed expected values for each access.
// -----------------------------------------------------------------------------
module tb_lsu_mem_port;
  localparam int ADDR_W = 17;

  localparam logic [5:0] ALU_LB  = 6'd11;
  localparam logic [5:0] ALU_LH  = 6'd12;
  localparam logic [5:0] ALU_LW  = 6'd13;
  localparam logic [5:0] ALU_LBU = 6'd14;
  localparam logic [5:0] ALU_LHU = 6'd15;
  localparam logic [5:0] ALU_SB  = 6'd16;
  localparam logic [5:0] ALU_SH  = 6'd17;
  localparam logic [5:0] ALU_SW  = 6'd18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [5:0]        alucode = '0;
  logic              is_load = 1'b0;
  logic              is_store = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              misalign_err;

  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR_W(ADDR_W)) mif ();

  lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .alucode      (alucode),
    .is_load      (is_load),
    .is_store     (is_store),
    .addr         (addr),
    .wdata        (wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .misalign_err (misalign_err),
    .mem          (mif.master)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model state and logs.
  logic [31:0]       mem_words [int];
  int                gnt_delay = 0;
  int                rv_delay = 0;
  int                wait_cnt = 0;
  bit                rd_pending = 0;
  int                rd_wait = 0;
  logic [31:0]       rd_word = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [3:0]        prev_strb = '0;
  logic [31:0]       prev_wdata = '0;
  logic              prev_we = 1'b0;

  int                txn_n = 0;
  logic [ADDR_W-1:0] t_addr [8];
  logic [3:0]        t_strb [8];
  logic [31:0]       t_wdata [8];
  logic              t_we [8];

  int                resp_cnt = 0;
  int                resp_cyc = 0;
  logic [31:0]       resp_dat = '0;
  logic              resp_err = 1'b0;

  function automatic logic [31:0] rd_mem(input int key);
    return mem_words.exists(key) ? mem_words[key] : 32'h0;
  endfunction

  // Responder and monitor: samples DUT at the falling edge, then drives the
  // grant / read return for the next rising edge.
  initial begin
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++;
        resp_cyc = cyc;
        resp_dat = resp_data;
        resp_err = misalign_err;
      end
      mif.mem_gnt    = 1'b0;
      mif.mem_rvalid = 1'b0;
      if (!rst_n) begin
        rd_pending = 0;
        wait_cnt   = 0;
      end else begin
        if (rd_pending) begin
          if (rd_wait == 0) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = rd_word;
            rd_pending     = 0;
          end else begin
            rd_wait--;
          end
        end
        if (mif.mem_req) begin
          if (wait_cnt > 0) begin
            check("req_stable_addr", 64'(mif.mem_addr), 64'(prev_addr));
            check("req_stable_we", 64'(mif.mem_we), 64'(prev_we));
            check("req_stable_strb", 64'(mif.mem_wstrb), 64'(prev_strb));
            check("req_stable_wdata", 64'(mif.mem_wdata), 64'(prev_wdata));
          end
          prev_addr  = mif.mem_addr;
          prev_we    = mif.mem_we;
          prev_strb  = mif.mem_wstrb;
          prev_wdata = mif.mem_wdata;
          if (wait_cnt >= gnt_delay) begin
            logic [31:0] w;
            int key;
            mif.mem_gnt = 1'b1;
            wait_cnt = 0;
            key = int'(mif.mem_addr >> 2);
            if (txn_n < 8) begin
              t_addr[txn_n]  = mif.mem_addr;
              t_strb[txn_n]  = mif.mem_wstrb;
              t_wdata[txn_n] = mif.mem_wdata;
              t_we[txn_n]    = mif.mem_we;
            end
            txn_n++;
            if (mif.mem_we) begin
              w = rd_mem(key);
              for (int b = 0; b < 4; b++)
                if (mif.mem_wstrb[b]) w[8*b +: 8] = mif.mem_wdata[8*b +: 8];
              mem_words[key] = w;
            end else begin
              rd_word    = rd_mem(key);
              rd_wait    = rv_delay;
              rd_pending = 1;
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic clear_logs();
    @(posedge clk);
    #1;
    txn_n    = 0;
    resp_cnt = 0;
  endtask

  // Present one request, wait (bounded) for its response, then allow a few
  // extra cycles so a duplicate resp_valid would be counted.
  task automatic issue(input string name, input logic [5:0] code, input logic ld,
                       input logic st, input logic [ADDR_W-1:0] a,
                       input logic [31:0] wd, output int lat);
    int acc_cyc;
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check({name, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    alucode   = code;
    is_load   = ld;
    is_store  = st;
    addr      = a;
    wdata     = wd;
    acc_cyc   = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    for (int i = 0; i < 40 && resp_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    check({name, "_resp_cnt"}, 64'(resp_cnt), 64'd1);
    lat = resp_cyc - acc_cyc + 1;
    $display("txn %s addr=0x%05h wdata=0x%08h mem_txns=%0d resp_data=0x%08h err=%0d lat=%0d",
             name, a, wd, txn_n, resp_dat, resp_err, lat);
  endtask

  task automatic ignored(input string name, input logic [5:0] code, input logic ld,
                         input logic st);
    clear_logs();
    @(negedge clk);
    req_valid = 1'b1;
    alucode   = code;
    is_load   = ld;
    is_store  = st;
    addr      = 17'h00004;
    @(negedge clk);
    req_valid = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    #1;
    check({name, "_still_ready"}, 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    #1;
    check({name, "_no_txn"}, 64'(txn_n), 64'd0);
    check({name, "_no_resp"}, 64'(resp_cnt), 64'd0);
    $display("txn %s ignored mem_txns=%0d resps=%0d", name, txn_n, resp_cnt);
  endtask

  initial begin
    int lat;

    // Reset values, before any clock edge.
    #2;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_mem_req", 64'(mif.mem_req), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_err", 64'(misalign_err), 64'd0);
    check("rst_wstrb", 64'(mif.mem_wstrb), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // SB into byte lane 2 of word 1.
    mem_words[1] = 32'h5555_5555;
    gnt_delay = 0;
    rv_delay  = 0;
    issue("sb_6", ALU_SB, 1'b0, 1'b1, 17'h00006, 32'h0000_00AB, lat);
    check("sb_txns", 64'(txn_n), 64'd1);
    check("sb_addr", 64'(t_addr[0]), 64'h4);
    check("sb_we", 64'(t_we[0]), 64'd1);
    check("sb_wstrb", 64'(t_strb[0]), 64'b0100);
    check("sb_wdata", 64'(t_wdata[0]), 64'h00AB_0000);
    check("sb_resp_data", 64'(resp_dat), 64'd0);
    check("sb_mem_word", 64'(rd_mem(1)), 64'h55AB_5555);

    // Signed and unsigned byte loads from the top lane; minimum latency.
    mem_words[0] = 32'h80FF_FF7F;
    issue("lb_3", ALU_LB, 1'b1, 1'b0, 17'h00003, 32'h0, lat);
    check("lb_data", 64'(resp_dat), 64'hFFFF_FF80);
    check("lb_addr", 64'(t_addr[0]), 64'h0);
    check("lb_we", 64'(t_we[0]), 64'd0);
    check("lb_latency", 64'(lat), 64'd4);
    issue("lbu_3", ALU_LBU, 1'b1, 1'b0, 17'h00003, 32'h0, lat);
    check("lbu_data", 64'(resp_dat), 64'h0000_0080);

    // Half load with the grant withheld for three cycles.
    mem_words[0] = 32'h8001_1234;
    gnt_delay = 3;
    issue("lh_2", ALU_LH, 1'b1, 1'b0, 17'h00002, 32'h0, lat);
    check("lh_data", 64'(resp_dat), 64'hFFFF_8001);
    check("lh_addr", 64'(t_addr[0]), 64'h0);
    check("lh_err", 64'(resp_err), 64'd0);
    gnt_delay = 0;

    // Word and unsigned half loads, slower read return.
    mem_words[1] = 32'hDEAD_BEEF;
    rv_delay = 2;
    issue("lw_4", ALU_LW, 1'b1, 1'b0, 17'h00004, 32'h0, lat);
    check("lw_data", 64'(resp_dat), 64'hDEAD_BEEF);
    issue("lhu_4", ALU_LHU, 1'b1, 1'b0, 17'h00004, 32'h0, lat);
    check("lhu_data", 64'(resp_dat), 64'h0000_BEEF);
    rv_delay = 0;

    // Upper half store.
    issue("sh_a", ALU_SH, 1'b0, 1'b1, 17'h0000A, 32'h1234_CAFE, lat);
    check("sh_addr", 64'(t_addr[0]), 64'h8);
    check("sh_wstrb", 64'(t_strb[0]), 64'b1100);
    check("sh_wdata", 64'(t_wdata[0]), 64'hCAFE_0000);

`ifdef MISALIGN_SPLIT_EN
    issue("sw_1_split", ALU_SW, 1'b0, 1'b1, 17'h00001, 32'h1122_3344, lat);
    check("split_txns", 64'(txn_n), 64'd2);
    check("split_p0_addr", 64'(t_addr[0]), 64'h0);
    check("split_p0_wstrb", 64'(t_strb[0]), 64'b1110);
    check("split_p0_wdata", 64'(t_wdata[0]), 64'h2233_4400);
    check("split_p1_addr", 64'(t_addr[1]), 64'h4);
    check("split_p1_wstrb", 64'(t_strb[1]), 64'b0001);
    check("split_p1_wdata", 64'(t_wdata[1]), 64'h0000_0011);
    check("split_err", 64'(resp_err), 64'd0);
    // Split load crossing the top word wraps to word 0.
    mem_words[32'h7FFF] = 32'hAABB_CCDD;
    mem_words[0]        = 32'h1122_3344;
    issue("lw_wrap", ALU_LW, 1'b1, 1'b0, 17'h1FFFE, 32'h0, lat);
    check("wrap_p0_addr", 64'(t_addr[0]), 64'h1FFFC);
    check("wrap_p1_addr", 64'(t_addr[1]), 64'h0);
    check("wrap_data", 64'(resp_dat), 64'h3344_AABB);
`else
    issue("lw_2_misalign", ALU_LW, 1'b1, 1'b0, 17'h00002, 32'h0, lat);
    check("mis_no_mem", 64'(txn_n), 64'd0);
    check("mis_err", 64'(resp_err), 64'd1);
    check("mis_data", 64'(resp_dat), 64'd0);
    check("mis_latency", 64'(lat), 64'd2);
    issue("lh_3_misalign", ALU_LH, 1'b1, 1'b0, 17'h00003, 32'h0, lat);
    check("mis_lh_err", 64'(resp_err), 64'd1);
    check("mis_lh_no_mem", 64'(txn_n), 64'd0);
`endif

    // Malformed requests are dropped.
    ignored("both_dir", ALU_LW, 1'b1, 1'b1);
    ignored("no_dir", ALU_LW, 1'b0, 1'b0);
    ignored("code_dir", ALU_LB, 1'b0, 1'b1);

    // Reset while waiting for a grant: mem_req must drop without a clock.
    gnt_delay = 20;
    clear_logs();
    @(negedge clk);
    req_valid = 1'b1;
    alucode   = ALU_LW;
    is_load   = 1'b1;
    addr      = 17'h00004;
    @(negedge clk);
    req_valid = 1'b0;
    is_load   = 1'b0;
    @(negedge clk);
    check("req0_mem_req", 64'(mif.mem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req0_mem_req", 64'(mif.mem_req), 64'd0);
    check("rst_req0_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;

    // Reset while waiting for read data.
    rv_delay = 6;
    clear_logs();
    @(negedge clk);
    req_valid = 1'b1;
    alucode   = ALU_LW;
    is_load   = 1'b1;
    addr      = 17'h00004;
    @(negedge clk);
    req_valid = 1'b0;
    is_load   = 1'b0;
    @(negedge clk);
    #1;
    check("rd0_granted", 64'(txn_n), 64'd1);
    check("rd0_not_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_rd0_mem_req", 64'(mif.mem_req), 64'd0);
    check("rst_rd0_ready", 64'(req_ready), 64'd1);
    check("rst_rd0_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("rst_no_resp", 64'(resp_cnt), 64'd0);
    $display("txn rst_mid_op resps=%0d", resp_cnt);

    rv_delay = 0;
    issue("lw_after_rst", ALU_LW, 1'b1, 1'b0, 17'h00004, 32'h0, lat);
    check("after_rst_data", 64'(resp_dat), 64'hDEAD_BEEF);
    check("after_rst_latency", 64'(lat), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
